// File: rtl/hmmm_pkg.sv
// Shared types and default sizes for the IO controller.
package hmmm_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_AW    = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    DONE,
    FLASH,
    FLASH_FULL
  } io_state_t;

  function automatic logic is_handshake(input io_state_t s);
    return (s == RD_WAIT) || (s == WR_WAIT);
  endfunction

endpackage

// File: rtl/io_timer.sv
// Handshake wait counter; expiry fires on the TIMEOUT-th enabled cycle.
module io_timer #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expiry
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expiry = (TIMEOUT != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/io_ctrl.sv
// Core-to-peripheral IO handshake controller with instruction-ROM flash streaming.
module io_ctrl
  import hmmm_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned AW      = DEFAULT_AW,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             FlashEnable,
  input  logic             IOReady,
  output logic             IOWaiting,
  input  logic [WIDTH-1:0] ParallelIn,
  output logic [WIDTH-1:0] ParallelOut,
  input  logic             ReadReq,
  input  logic             WriteReq,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] ReadData,
  output logic             IOStall,
  output logic             FlashWE,
  output logic [AW-1:0]    FlashAdr,
  output logic [WIDTH-1:0] FlashData,
  output logic             FlashFull,
  output logic             IOErr
);

  localparam logic [AW-1:0] LAST_ADR = '1;

  io_state_t     state, state_next;
  logic [AW-1:0] count;
  logic          waiting, expiry;
  logic          load_read, zero_read, load_out, set_err, flash_wr, flash_clear;

  assign waiting = is_handshake(state);

  // Held clear outside the wait states, so every handshake starts from zero.
  io_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!waiting),
    .enable (waiting),
    .expiry (expiry)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    IOStall     = 1'b0;
    IOWaiting   = 1'b0;
    load_read   = 1'b0;
    zero_read   = 1'b0;
    load_out    = 1'b0;
    set_err     = 1'b0;
    flash_wr    = 1'b0;
    flash_clear = 1'b0;
    case (state)
      IDLE: begin
        IOStall = FlashEnable | ReadReq | WriteReq;
        if (FlashEnable) begin
          state_next = FLASH;
        end else if (ReadReq) begin
          state_next = RD_WAIT;
        end else if (WriteReq) begin
          state_next = WR_WAIT;
          load_out   = 1'b1;
        end
      end
      RD_WAIT: begin
        IOStall   = 1'b1;
        IOWaiting = 1'b1;
        if (IOReady) begin
          load_read  = 1'b1;
          state_next = DONE;
        end else if (expiry) begin
          zero_read  = 1'b1;
          set_err    = 1'b1;
          state_next = DONE;
        end
      end
      WR_WAIT: begin
        IOStall   = 1'b1;
        IOWaiting = 1'b1;
        if (IOReady) begin
          state_next = DONE;
        end else if (expiry) begin
          set_err    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      FLASH: begin
        IOStall   = 1'b1;
        IOWaiting = 1'b1;
        if (!FlashEnable) begin
          flash_clear = 1'b1;
          state_next  = IDLE;
        end else if (IOReady) begin
          flash_wr = 1'b1;
          if (count == LAST_ADR) state_next = FLASH_FULL;
        end
      end
      FLASH_FULL: begin
        IOStall = 1'b1;
        if (!FlashEnable) begin
          flash_clear = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      ReadData    <= '0;
      ParallelOut <= '0;
      IOErr       <= 1'b0;
      FlashFull   <= 1'b0;
    end else begin
      if (load_read)      ReadData <= ParallelIn;
      else if (zero_read) ReadData <= '0;
      if (load_out) ParallelOut <= WriteData;
      if (set_err)  IOErr <= 1'b1;
      // The last address is held rather than wrapped so a full ROM never shows address 0.
      if (flash_clear) begin
        count     <= '0;
        FlashFull <= 1'b0;
      end else if (flash_wr) begin
        if (count == LAST_ADR) FlashFull <= 1'b1;
        else                   count <= count + AW'(1);
      end
    end
  end

  assign FlashWE   = flash_wr && !reset;
  assign FlashAdr  = count;
  assign FlashData = ParallelIn;

endmodule

// File: tb/tb_io_ctrl.sv
// Scoreboard bench for io_ctrl with AW=3 and TIMEOUT=5.
module tb_io_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        FlashEnable, IOReady, IOWaiting;
  logic [15:0] ParallelIn, ParallelOut;
  logic        ReadReq, WriteReq;
  logic [15:0] WriteData, ReadData;
  logic        IOStall, FlashWE;
  logic [2:0]  FlashAdr;
  logic [15:0] FlashData;
  logic        FlashFull, IOErr;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  logic [15:0] rd_q[$];
  logic [15:0] wr_q[$];
  logic [31:0] flash_q[$];

  io_ctrl #(.WIDTH(16), .AW(3), .TIMEOUT(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .FlashEnable (FlashEnable),
    .IOReady     (IOReady),
    .IOWaiting   (IOWaiting),
    .ParallelIn  (ParallelIn),
    .ParallelOut (ParallelOut),
    .ReadReq     (ReadReq),
    .WriteReq    (WriteReq),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .IOStall     (IOStall),
    .FlashWE     (FlashWE),
    .FlashAdr    (FlashAdr),
    .FlashData   (FlashData),
    .FlashFull   (FlashFull),
    .IOErr       (IOErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (FlashWE === 1'b1) begin
      we_count++;
      if (flash_q.size() == 0) check("flash_we_unexpected", {13'b0, FlashAdr, FlashData}, 32'hFFFF_FFFF);
      else check("flash_wr", {13'b0, FlashAdr, FlashData}, flash_q.pop_front());
    end
  end

  task automatic do_read(input string tag, input logic [15:0] din, input int ready_at,
                         input logic [15:0] exp_data, input int exp_stall, input logic exp_err);
    int stalls = 0;
    bit done = 0;
    rd_q.push_back(exp_data);
    ParallelIn = din;
    ReadReq    = 1'b1;
    IOReady    = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c == ready_at) IOReady = 1'b1;
      @(negedge clk);
      if (!IOStall) done = 1;
      else begin
        stalls++;
        next_cycle();
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_stall"}, stalls, exp_stall);
    check({tag, "_data"}, ReadData, rd_q.pop_front());
    check({tag, "_err"}, IOErr, exp_err);
    check({tag, "_waiting"}, IOWaiting, 0);
    next_cycle();
    ReadReq = 1'b0;
    IOReady = 1'b0;
    @(negedge clk);
    check({tag, "_idle_stall"}, IOStall, 0);
    check({tag, "_idle_wait"}, IOWaiting, 0);
    check({tag, "_hold"}, ReadData, exp_data);
    next_cycle();
  endtask

  task automatic do_write(input string tag, input logic [15:0] data, input int ready_at);
    int waits = 0;
    bit done = 0;
    wr_q.push_back(data);
    WriteData = data;
    WriteReq  = 1'b1;
    IOReady   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c == ready_at) IOReady = 1'b1;
      @(negedge clk);
      if (c == 1) check({tag, "_pout"}, ParallelOut, wr_q.pop_front());
      if (IOWaiting) waits++;
      if (!IOStall) done = 1;
      else next_cycle();
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_waits"}, waits, ready_at);
    next_cycle();
    WriteReq = 1'b0;
    IOReady  = 1'b0;
    @(negedge clk);
    check({tag, "_idle_stall"}, IOStall, 0);
    next_cycle();
  endtask

  initial begin
    reset = 1'b1; FlashEnable = 1'b0; IOReady = 1'b0; ParallelIn = '0;
    ReadReq = 1'b0; WriteReq = 1'b0; WriteData = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_readdata", ReadData, 0);
    check("rst_pout", ParallelOut, 0);
    check("rst_err", IOErr, 0);
    check("rst_full", FlashFull, 0);
    check("rst_we", FlashWE, 0);
    check("rst_adr", FlashAdr, 0);
    check("rst_stall", IOStall, 0);
    check("rst_waiting", IOWaiting, 0);
    next_cycle();
    reset = 1'b0;

    do_read("rd_beef", 16'hBEEF, 4, 16'hBEEF, 5, 1'b0);
    do_read("rd_min", 16'h5A5A, 1, 16'h5A5A, 2, 1'b0);
    do_write("wr", 16'h1234, 3);
    do_read("rd_edge", 16'hCAFE, 5, 16'hCAFE, 6, 1'b0);
    do_read("rd_to", 16'h7777, 100, 16'h0000, 6, 1'b1);
    do_write("wr2", 16'hABCD, 1);
    @(negedge clk);
    check("err_sticky", IOErr, 1);
    next_cycle();

    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst2_err", IOErr, 0);
    check("rst2_pout", ParallelOut, 0);
    check("rst2_readdata", ReadData, 0);
    next_cycle();

    // Priority: all requests together must pick FLASH
    FlashEnable = 1'b1; ReadReq = 1'b1; WriteReq = 1'b1; WriteData = 16'hFFFF;
    @(negedge clk);
    check("prio_stall", IOStall, 1);
    next_cycle();
    ReadReq = 1'b0; WriteReq = 1'b0;
    @(negedge clk);
    check("prio_waiting", IOWaiting, 1);
    check("prio_pout", ParallelOut, 0);
    check("prio_no_we", FlashWE, 0);
    next_cycle();
    we_count = 0;
    for (int i = 0; i < 3; i++) begin
      IOReady = 1'b1;
      ParallelIn = 16'h0100 + 16'(i);
      flash_q.push_back({13'b0, 3'(i), 16'h0100 + 16'(i)});
      next_cycle();
    end
    reset = 1'b1; ParallelIn = 16'hDEAD;
    @(negedge clk);
    check("rstf_we", FlashWE, 0);
    check("rstf_adr_before", FlashAdr, 3);
    next_cycle();
    reset = 1'b0; FlashEnable = 1'b0; IOReady = 1'b0;
    @(negedge clk);
    check("rstf_adr", FlashAdr, 0);
    check("rstf_waiting", IOWaiting, 0);
    check("rstf_stall", IOStall, 0);
    check("rstf_we_count", we_count, 3);
    check("rstf_q_empty", flash_q.size(), 0);
    next_cycle();

    // Dropping FlashEnable with IOReady high must not write
    FlashEnable = 1'b1;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      IOReady = 1'b1;
      ParallelIn = 16'h0020 + 16'(i);
      flash_q.push_back({13'b0, 3'(i), 16'h0020 + 16'(i)});
      next_cycle();
    end
    FlashEnable = 1'b0; ParallelIn = 16'h0BAD;
    @(negedge clk);
    check("abort_we", FlashWE, 0);
    next_cycle();
    IOReady = 1'b0;
    @(negedge clk);
    check("abort_adr", FlashAdr, 0);
    check("abort_stall", IOStall, 0);
    next_cycle();

    we_count = 0;
    FlashEnable = 1'b1;
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      IOReady = 1'b1;
      ParallelIn = 16'(i);
      if (i < 8) flash_q.push_back({13'b0, 3'(i), 16'(i)});
      next_cycle();
    end
    IOReady = 1'b0;
    @(negedge clk);
    check("full_flag", FlashFull, 1);
    check("full_waiting", IOWaiting, 0);
    check("full_stall", IOStall, 1);
    check("full_we_count", we_count, 8);
    check("full_q_empty", flash_q.size(), 0);
    next_cycle();
    FlashEnable = 1'b0;
    next_cycle();
    @(negedge clk);
    check("full_clear", FlashFull, 0);
    check("full_adr", FlashAdr, 0);
    check("full_idle_stall", IOStall, 0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/io_ctrl.md
IO_CTRL -- requirements
Module: io_ctrl

Interface
REQ-001 Parameters, one per line as name, default, meaning:
  - WIDTH, 16, data word width.
  - AW, 8, flash address width; the instruction ROM depth is 2^AW.
  - TIMEOUT, 0, maximum wait cycles in a handshake state; 0 disables the timeout.
REQ-002 Ports, one per line as name, direction, width, meaning:
  - clk  in  1  single clock.
  - reset  in  1  synchronous, active-high reset.
  - FlashEnable  in  1  request to stream code into the instruction ROM.
  - IOReady  in  1  off-chip peripheral handshake.
  - IOWaiting  out  1  core is waiting on the peripheral.
  - ParallelIn  in  WIDTH  peripheral input word.
  - ParallelOut  out  WIDTH  registered peripheral output word.
  - ReadReq  in  1  core is executing a read instruction.
  - WriteReq  in  1  core is executing a write instruction.
  - WriteData  in  WIDTH  word to send to the peripheral.
  - ReadData  out  WIDTH  registered word received from the peripheral.
  - IOStall  out  1  holds the core PC.
  - FlashWE  out  1  ROM write strobe.
  - FlashAdr  out  AW  ROM write address.
  - FlashData  out  WIDTH  ROM write data.
  - FlashFull  out  1  all 2^AW ROM words have been written.
  - IOErr  out  1  sticky timeout flag.
REQ-003 The block SHALL have one clock, clk; reset SHALL be synchronous and active-high on port reset.

Function
REQ-004 The FSM SHALL have states IDLE, RD_WAIT, WR_WAIT, DONE, FLASH, FLASH_FULL.
REQ-005 IDLE transitions SHALL have priority FlashEnable > ReadReq > WriteReq:
  - FlashEnable -> FLASH.
  - ReadReq -> RD_WAIT.
  - WriteReq -> WR_WAIT, with ParallelOut <= WriteData on the same edge.
REQ-006 IOStall SHALL equal 1 in these cases, and 0 otherwise (combinational):
  - IDLE with any of FlashEnable, ReadReq or WriteReq high.
  - RD_WAIT, WR_WAIT, FLASH and FLASH_FULL.
REQ-007 IOWaiting SHALL be 1 exactly in RD_WAIT, WR_WAIT and FLASH.
REQ-008 In RD_WAIT, IOReady=1 SHALL load ReadData <= ParallelIn and go to DONE; in WR_WAIT, IOReady=1 SHALL go to DONE.
REQ-009 In DONE, IOStall=0 and all requests SHALL be ignored; DONE SHALL go to IDLE unconditionally, so that a held ReadReq/WriteReq does not re-trigger.
REQ-010 Minimum read/write latency SHALL be 3 cycles from request in IDLE to IOStall low; ReadData SHALL be valid in DONE and hold until the next read.
REQ-011 With TIMEOUT>0, a wait counter SHALL:
  - clear on entry to RD_WAIT or WR_WAIT;
  - increment each waiting cycle;
  - on reaching TIMEOUT without IOReady, set IOErr=1 (sticky), set ReadData <= 0 for reads, and go to DONE.
REQ-012 IOReady and TIMEOUT expiry in the same cycle SHALL complete normally, without setting IOErr.
REQ-013 Each FLASH cycle with IOReady=1 SHALL assert FlashWE for that cycle only, drive FlashData=ParallelIn and FlashAdr=count, then increment count.
REQ-014 A FLASH write at count=2^AW-1 SHALL go to FLASH_FULL and set FlashFull=1; FlashWE SHALL never assert in FLASH_FULL (no wrap-around overwrite).
REQ-015 FlashEnable=0 in FLASH or FLASH_FULL SHALL go to IDLE and clear count and FlashFull; any FlashWE in that same cycle SHALL be suppressed.
REQ-016 FlashEnable rising during RD_WAIT, WR_WAIT or DONE SHALL be ignored until IDLE is reached.
REQ-017 FlashAdr SHALL equal count in all states; FlashData SHALL equal ParallelIn combinationally.

Reset
REQ-018 reset SHALL force IDLE and set the following to 0: count, wait counter, ReadData, ParallelOut, IOErr, FlashFull, FlashWE.
REQ-019 reset mid-handshake or mid-flash SHALL abort without a FlashWE pulse in the reset cycle; reset SHALL be the only way to clear IOErr.

Structure
REQ-020 Shared package hmmm_pkg SHALL hold the io_state_t enum and default WIDTH/AW constants.
REQ-021 The wait counter SHALL be a sub-module io_timer (clear, enable, expiry); the remainder SHALL be a single FSM plus registers.

Verification
REQ-022 Read handshake: ReadReq=1 held, ParallelIn=16'hBEEF, IOReady raised 4 cycles later -> IOStall=1 for 5 cycles, then DONE with ReadData=16'hBEEF and IOStall=0; no second RD_WAIT.
REQ-023 Write handshake: WriteReq=1, WriteData=16'h1234 -> ParallelOut=16'h1234 next cycle; IOWaiting=1 until IOReady, then DONE.
REQ-024 Flash full, AW=3: FlashEnable=1, IOReady=1 for 10 cycles, data 0..9 -> exactly 8 FlashWE pulses, addresses 0..7 with data 0..7, FlashFull=1, addresses not rewritten.
REQ-025 Timeout, TIMEOUT=5: ReadReq held, IOReady=0 -> IOErr=1 and ReadData=0 after 5 wait cycles, DONE then IDLE; IOErr remains 1 until reset.
REQ-026 Priority and reset: FlashEnable, ReadReq and WriteReq all high in IDLE -> FLASH entered; reset asserted mid-FLASH at count=3 -> IDLE, FlashAdr=0, no FlashWE during the reset cycle.
